// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type and widths for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam int LANE_W = 8;
  localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_byte_lane.sv
// dmem_byte_lane: byte-lane merge for stores and sign-extending lane select for loads.
module dmem_byte_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic        byte_acc,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data
);
  logic [LANE_W-1:0] rb;
  always_comb begin
    rb = word[int'(lane) * LANE_W +: LANE_W];
    wr_word = word;
    wr_word[int'(lane) * LANE_W +: LANE_W] = wdata[LANE_W-1:0];
    if (!byte_acc) wr_word = wdata;
    rd_data = byte_acc ? {{(32 - LANE_W){rb[LANE_W-1]}}, rb} : word;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency valid/ready data-memory slave with stall output.
// Define DMEM_ALIGN_CHECK_EN to flag and suppress misaligned word accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [31:0] mem [2**ADDR_W];
  logic [31:0] data_q, wr_word, rd_data, ld_data;
  logic [ADDR_W-1:0] idx;
  logic err, err_q, acc, unused;
  assign acc = req_valid && req_ready;
  assign idx = req_addr[ADDR_W+1:2];
  assign stall = req_valid && !req_ready;
  assign unused = ^req_addr[31:ADDR_W+2];
`ifdef DMEM_ALIGN_CHECK_EN
  assign err = !req_byte && (req_addr[1:0] != 2'b00);
`else
  assign err = 1'b0;
`endif
  assign ld_data = (err || req_we) ? 32'd0 : rd_data;
  dmem_byte_lane u_lane (
    .lane(req_addr[1:0]),
    .word(mem[idx]),
    .wdata(req_wdata),
    .byte_acc(req_byte),
    .wr_word(wr_word),
    .rd_data(rd_data)
  );
  // Array has no reset so contents survive a mid-operation reset.
  always_ff @(posedge clk)
    if (acc && req_we && !err && !reset) mem[idx] <= wr_word;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (acc) begin
        data_q <= ld_data;
        err_q <= err;
      end
      if (acc && LATENCY > 1) begin
        state <= BUSY;
        cnt <= CNT_INIT;
        req_ready <= 1'b0;
        rsp_valid <= 1'b0;
      end else if (acc) begin
        state <= RESP;
        req_ready <= 1'b1;
        rsp_valid <= 1'b1;
        rsp_rdata <= ld_data;
        rsp_err <= err;
      end else if (state == BUSY && cnt == 1) begin
        state <= RESP;
        req_ready <= 1'b1;
        rsp_valid <= 1'b1;
        rsp_rdata <= data_q;
        rsp_err <= err_q;
      end else if (state == BUSY) begin
        cnt <= cnt - 1'b1;
      end else begin
        state <= IDLE;
        req_ready <= 1'b1;
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table-driven bench for dmem_responder.
module tb_dmem_responder;
  localparam int LAT = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit AC = 1'b1;
`else
  localparam bit AC = 1'b0;
`endif
  typedef struct {
    logic we;
    logic by;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic err;
  } vec_t;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_we = 0, req_byte = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err, stall;
  logic [31:0] rsp_rdata;
  logic b_valid = 0, b_we = 0, b_byte = 0;
  logic [31:0] b_addr = 0, b_wdata = 0;
  logic b_ready, b_rvalid, b_err, b_stall;
  logic [31:0] b_rdata;
  int checks = 0, errors = 0;
  vec_t tbl [14];
  logic [31:0] exp3 [8];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall)
  );
  dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(b_we), .req_byte(b_byte), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rvalid), .rsp_rdata(b_rdata), .rsp_err(b_err), .stall(b_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    req_valid = 1; req_we = t.we; req_byte = t.by; req_addr = t.addr; req_wdata = t.wdata;
  endtask

  task automatic req(input vec_t t, input string name);
    bit got = 0;
    @(negedge clk);
    chk({name, "_ready"}, {31'd0, req_ready}, 32'd1);
    drive(t);
    for (int n = 1; n <= 16 && !got; n++) begin
      @(negedge clk);
      req_valid = 0;
      if (rsp_valid) begin
        got = 1;
        chk({name, "_lat"}, n, LAT);
        chk({name, "_rdata"}, rsp_rdata, t.rdata);
        chk({name, "_err"}, {31'd0, rsp_err}, {31'd0, t.err});
      end
    end
    if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    tbl[0]  = '{1, 0, 32'h20,   32'h11223344, 32'h0, 0};
    tbl[1]  = '{1, 1, 32'h21,   32'h000000AA, 32'h0, 0};
    tbl[2]  = '{0, 0, 32'h20,   32'h0, 32'h1122AA44, 0};
    tbl[3]  = '{0, 1, 32'h21,   32'h0, 32'hFFFFFFAA, 0};
    tbl[4]  = '{0, 1, 32'h20,   32'h0, 32'h00000044, 0};
    tbl[5]  = '{1, 1, 32'h23,   32'h12345680, 32'h0, 0};
    tbl[6]  = '{0, 0, 32'h20,   32'h0, 32'h8022AA44, 0};
    tbl[7]  = '{0, 1, 32'h23,   32'h0, 32'hFFFFFF80, 0};
    tbl[8]  = '{1, 0, 32'h1000, 32'h5A5A5A5A, 32'h0, 0};
    tbl[9]  = '{0, 0, 32'h0,    32'h0, 32'h5A5A5A5A, 0};
    tbl[10] = '{1, 0, 32'h22,   32'hCAFEF00D, 32'h0, AC};
    tbl[11] = '{0, 0, 32'h20,   32'h0, AC ? 32'h8022AA44 : 32'hCAFEF00D, 0};
    tbl[12] = '{0, 0, 32'h22,   32'h0, AC ? 32'h0 : 32'hCAFEF00D, AC};
    tbl[13] = '{0, 1, 32'h22,   32'h0, AC ? 32'h00000022 : 32'hFFFFFFFE, 0};
    for (int i = 0; i < 8; i++) exp3[i] = (i < 4) ? 32'h0 : (32'hA0000000 | (i - 4));

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    reset = 0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // store then load held back-to-back to exercise stall during BUSY
    drive('{1, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0});
    @(negedge clk);
    drive('{0, 0, 32'h10, 32'h0, 32'h0, 0});
    chk("t1_stall_busy", {31'd0, stall}, 32'd1);
    chk("t1_nvalid1", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("t1_sw_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t1_sw_rdata", rsp_rdata, 32'd0);
    chk("t1_stall_resp", {31'd0, stall}, 32'd0);
    @(negedge clk);
    req_valid = 0;
    chk("t1_nvalid3", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("t1_lw_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t1_lw_rdata", rsp_rdata, 32'hDEADBEEF);

    for (int i = 0; i < 14; i++) req(tbl[i], $sformatf("vec%0d", i));

    // reset while a load is pending in BUSY
    req('{1, 0, 32'h40, 32'h13579BDF, 32'h0, 0}, "t4_sw");
    @(negedge clk);
    drive('{0, 0, 32'h40, 32'h0, 32'h0, 0});
    @(negedge clk);
    req_valid = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("t4_ready_rst", {31'd0, req_ready}, 32'd0);
    chk("t4_nvalid_rst", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("t4_ready_after", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_nvalid%0d", i), {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    req('{0, 0, 32'h40, 32'h0, 32'h13579BDF, 0}, "t4_lw");

    // LATENCY=1 streaming: four stores then four loads with valid held high
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("t3_valid%0d", i - 1), {31'd0, b_rvalid}, 32'd1);
        chk($sformatf("t3_rdata%0d", i - 1), b_rdata, exp3[i-1]);
      end
      chk($sformatf("t3_ready%0d", i), {31'd0, b_ready}, 32'd1);
      b_valid = 1;
      b_we = (i < 4);
      b_byte = 0;
      b_addr = 32'(4 * (i % 4));
      b_wdata = 32'hA0000000 | i;
    end
    @(negedge clk);
    chk("t3_valid7", {31'd0, b_rvalid}, 32'd1);
    chk("t3_rdata7", b_rdata, exp3[7]);
    b_valid = 0;
    @(negedge clk);
    chk("t3_idle", {31'd0, b_rvalid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
